// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder family.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic cout;
    logic v;
    logic z;
  } add_flags_t;

  function automatic int unsigned slice_w(int unsigned width, int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit adder slice with carry in and carry out.
module adder_slice #(
  parameter int unsigned SW = 8
) (
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic          i_ci,
  output logic [SW-1:0] o_s,
  output logic          o_co
);

  logic [SW:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SW{1'b0}}, i_ci};
  assign o_s    = w_full[SW-1:0];
  assign o_co   = w_full[SW];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: one SW-bit slice is resolved per stage and the slice carry
// travels with its transaction through the stage registers under a global stall.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             V,
  output logic             Z
);

  localparam int unsigned SW   = slice_w(WIDTH, STAGES);
  localparam int unsigned LAST = STAGES - 1;

  if (STAGES == 0 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipe_adder: STAGES must be >= 1 and divide WIDTH");
  end

  logic                          w_advance;
  logic                          w_sub;
  logic                          w_v;
  logic                          w_unused;
  add_flags_t                    w_flags;
  logic [STAGES-1:0]             w_in_vld, w_in_c, w_in_z, w_nxt_z, w_slice_c;
  logic [STAGES-1:0][WIDTH-1:0]  w_in_a, w_in_b, w_in_sum, w_nxt_sum;
  logic [STAGES-1:0][SW-1:0]     w_slice_s;

  logic [STAGES-1:0]             r_vld, r_c, r_z;
  logic [STAGES-1:0][WIDTH-1:0]  r_a, r_b, r_sum;
  logic                          r_v;

  assign w_sub     = (op_e'(Op) == OP_SUB);
  assign w_advance = !r_vld[LAST] || out_ready;
  assign in_ready  = w_advance;

  // Stage k consumes what stage k-1 registered; stage 0 takes the operand set directly.
  always_comb begin
    w_in_vld[0] = in_valid;
    w_in_a[0]   = A;
    w_in_b[0]   = w_sub ? ~B : B;
    w_in_c[0]   = w_sub ? ~Cin : Cin;
    w_in_sum[0] = '0;
    w_in_z[0]   = 1'b1;
    for (int k = 1; k < STAGES; k++) begin
      w_in_vld[k] = r_vld[k-1];
      w_in_a[k]   = r_a[k-1];
      w_in_b[k]   = r_b[k-1];
      w_in_c[k]   = r_c[k-1];
      w_in_sum[k] = r_sum[k-1];
      w_in_z[k]   = r_z[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_slice #(
      .SW (SW)
    ) u_slice (
      .i_a  (w_in_a[k][k*SW +: SW]),
      .i_b  (w_in_b[k][k*SW +: SW]),
      .i_ci (w_in_c[k]),
      .o_s  (w_slice_s[k]),
      .o_co (w_slice_c[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_nxt_sum[k]               = w_in_sum[k];
      w_nxt_sum[k][k*SW +: SW]   = w_slice_s[k];
      w_nxt_z[k]                 = w_in_z[k] & ~|w_slice_s[k];
    end
  end

  assign w_v = (w_in_a[LAST][WIDTH-1] == w_in_b[LAST][WIDTH-1]) &&
               (w_nxt_sum[LAST][WIDTH-1] != w_in_a[LAST][WIDTH-1]);

  // Bubbles shift along with real transactions; everything holds while the output stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= '0;
      r_z   <= '0;
      r_sum <= '0;
      r_v   <= 1'b0;
    end else if (w_advance) begin
      r_vld <= w_in_vld;
      r_a   <= w_in_a;
      r_b   <= w_in_b;
      r_c   <= w_slice_c;
      r_z   <= w_nxt_z;
      r_sum <= w_nxt_sum;
      r_v   <= w_v;
    end
  end

  assign w_flags   = '{cout: r_c[LAST], v: r_v, z: r_z[LAST]};
  assign out_valid = r_vld[LAST];
  assign Sum       = r_sum[LAST];
  assign Cout      = w_flags.cout;
  assign V         = w_flags.v;
  assign Z         = w_flags.z;

  // Already-consumed operand slices are carried for simplicity and never read.
  assign w_unused = ^{r_a[LAST], r_b[LAST], w_in_a, w_in_b};

endmodule

// File: tb/tb_pipe_adder.sv
// Randomised and directed bench for pipe_adder against an arithmetic reference model.
module tb_pipe_adder;

  localparam int W = 32;
  localparam int S = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         v;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         op = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout, v, z;

  logic         iv8 = 1'b0, ir8, ov8, c8, v8, z8;
  logic [7:0]   s8;
  logic         iv64 = 1'b0, ir64, ov64, c64, v64, z64;
  logic [63:0]  s64;

  int   n_tests = 0;
  int   n_fail = 0;
  int   n_out = 0;
  exp_t q[$];
  exp_t e_pop;
  logic hold_pend = 1'b0;
  logic [W+2:0] held;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
    .Cin(cin), .Op(op), .out_valid(out_valid), .out_ready(out_ready), .Sum(sum),
    .Cout(cout), .V(v), .Z(z)
  );

  pipe_adder #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(8'hFF), .B(8'h01),
    .Cin(1'b0), .Op(1'b0), .out_valid(ov8), .out_ready(1'b1), .Sum(s8),
    .Cout(c8), .V(v8), .Z(z8)
  );

  pipe_adder #(.WIDTH(64), .STAGES(8)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .A({64{1'b1}}),
    .B(64'd1), .Cin(1'b0), .Op(1'b0), .out_valid(ov64), .out_ready(1'b1), .Sum(s64),
    .Cout(c64), .V(v64), .Z(z64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result as a true integer: carry from the unsigned total, V from the signed total.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tc, input logic top);
    exp_t                e;
    logic        [W:0]   ua, ub, uc, ur;
    logic signed [W+1:0] sa, sb, sc, sr;
    ua = {1'b0, ta};
    ub = {1'b0, tb};
    uc = {{W{1'b0}}, tc};
    sa = {{2{ta[W-1]}}, ta};
    sb = {{2{tb[W-1]}}, tb};
    sc = {{(W+1){1'b0}}, tc};
    if (!top) begin
      ur     = ua + ub + uc;
      e.cout = ur[W];
      sr     = sa + sb + sc;
    end else begin
      ur     = ua - ub - uc;
      e.cout = (ua >= ub + uc);
      sr     = sa - sb - sc;
    end
    e.sum = ur[W-1:0];
    e.v   = (sr[W+1:W-1] != {3{sr[W-1]}});
    e.z   = (e.sum == '0);
    return e;
  endfunction

  // Compare process: sampled 1 time unit after each falling edge, ahead of the next rise.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      q.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && out_valid) check("hold stable", {sum, cout, v, z}, held);
      hold_pend = out_valid && !out_ready;
      held      = {sum, cout, v, z};
      check("in_ready rule", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          check("output with no pending txn", out_valid, 1'b0);
        end else begin
          e_pop = q.pop_front();
          check("result", {sum, cout, v, z}, e_pop);
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin, op));
    end
  end

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    cin      = 1'($urandom_range(0, 1));
    op       = 1'($urandom_range(0, 1));
  endtask

  // Returns once the operand set is guaranteed to transfer on the next rising edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input logic top);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    cin      = tc;
    op       = top;
    #2;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      #2;
      guard++;
    end
    if (!in_ready) check("send timeout", in_ready, 1'b1);
  endtask

  task automatic run_one(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic top, input logic [W-1:0] es,
                         input logic ec, input logic ev, input logic ez);
    int cnt;
    send(ta, tb, tc, top);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    check({name, " latency"}, 64'(cnt), 64'(S));
    check({name, " sum"}, sum, es);
    check({name, " cout"}, cout, ec);
    check({name, " v"}, v, ev);
    check({name, " z"}, z, ez);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, cnt;
    #1;
    check("reset out_valid", out_valid, 1'b0);
    check("reset sum", sum, 0);
    check("reset cout", cout, 1'b0);
    check("reset v", v, 1'b0);
    check("reset z", z, 1'b0);
    check("reset in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) idle();

    run_one("add wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    run_one("sub 5-7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_one("sub 7-5-1", 32'd7, 32'd5, 1'b1, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0);
    run_one("add ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_one("sub ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    repeat (S) idle();

    // Back-to-back stream: all 64 results must be out S+1 cycles after the last input.
    n0 = n_out;
    for (int i = 0; i < 64; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle();
    repeat (S) @(negedge clk);
    #2 check("stream count", 64'(n_out - n0), 64'd64);
    check("stream drained", 64'(q.size()), 64'd0);

    // Output stalled for 10 cycles mid-stream.
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 3) == 0) idle();
          send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle();
      end
      begin
        repeat (8) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("stall out_valid", out_valid, 1'b1);
        check("stall in_ready", in_ready, 1'b0);
        repeat (7) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    repeat (S + 2) idle();
    #2 check("stall count", 64'(n_out - n0), 64'd40);
    check("stall drained", 64'(q.size()), 64'd0);

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", out_valid, 1'b0);
    check("async rst sum", sum, 0);
    check("async rst flags", {cout, v, z}, 3'b000);
    check("async rst in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (S + 3) idle();
    run_one("post-rst 2+3", 32'd2, 32'd3, 1'b0, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);
    repeat (S) idle();

    // Scenario 1 on the narrow single-stage and the wide eight-stage instances.
    @(negedge clk);
    iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    #1;
    cnt = 1;
    while (!ov8 && cnt < 20) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    check("w8 latency", 64'(cnt), 64'd1);
    check("w8 result", {s8, c8, v8, z8}, {8'h00, 3'b101});

    @(negedge clk);
    iv64 = 1'b1;
    @(negedge clk);
    iv64 = 1'b0;
    #1;
    cnt = 1;
    while (!ov64 && cnt < 20) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    check("w64 latency", 64'(cnt), 64'd8);
    check("w64 sum", s64, 64'd0);
    check("w64 flags", {c64, v64, z64}, 3'b101);

    check("final queue empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined add/subtract unit: the registered, flow-controlled successor to the combinational `rca`/`cla`/`prefix_adder` family. It splits a WIDTH-bit operation into STAGES equal slices and resolves one slice per cycle, passing the slice carry through pipeline registers. It adds subtract mode, status flags and valid/ready handshaking on both sides. It sits between operand-producing logic and any consumer that needs full-throughput arithmetic at a clock rate a single-cycle adder cannot meet.

## Interface
- `WIDTH`, 32: operand and result width. Must be divisible by STAGES.
- `STAGES`, 4: number of pipeline stages, ≥1; slice width `SW = WIDTH/STAGES`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: the input operand set is valid.
- `in_ready` out 1: the unit accepts input this cycle.
- `A` in WIDTH: operand A.
- `B` in WIDTH: operand B.
- `Cin` in 1: carry-in for ADD, borrow-in for SUB.
- `Op` in 1: `OP_ADD`=0, `OP_SUB`=1.
- `out_valid` out 1: the result is valid.
- `out_ready` in 1: the consumer accepts the result.
- `Sum` out WIDTH: result.
- `Cout` out 1: carry-out for ADD; for SUB, 1 means no borrow.
- `V` out 1: signed (two's-complement) overflow.
- `Z` out 1: `Sum` is all zeros.

## Operation
- **ADD:** `{Cout,Sum} = A + B + Cin`.
- **SUB:** `{Cout,Sum} = A + ~B + !Cin`, which equals `A − B − Cin`.
  - `B' = Op ? ~B : B`.
  - `c0 = Op ? !Cin : Cin`.
- **Stage k** (0..STAGES-1):
  - Adds slice k of A and B' plus the carry registered from stage k-1 (stage 0 uses c0).
  - Registers the slice sum and the slice carry-out.
- **Skew registers:**
  - Unprocessed upper slices of A and B' travel with their transaction.
  - Completed lower sum slices also travel with it.
- **Zero flag:** a running zero bit per transaction, `z_k = z_{k-1} & (slice_sum_k == 0)`. `Z` is the final value.
- **Overflow:** `V = (A[W-1] == B'[W-1]) && (Sum[W-1] != A[W-1])`. It is computed in the last stage.
- **Flow control:** one per-stage valid bit, with a global stall.
  - `advance = !out_valid || out_ready`.
  - `in_ready = advance`.
  - A transfer occurs when `in_valid && in_ready`.
  - While `advance` = 0, all stage registers hold, including bubbles.
  - Bubbles are not collapsed.
- **Ordering:** results leave in input order. There is no loss and no duplication.
- **Out-register:** the output register is the final stage register. Outputs are stable while `out_valid && !out_ready`.

## Timing
- **Latency:** a transaction accepted at edge n appears with `out_valid`=1 after edge n+STAGES-1, i.e. STAGES cycles from acceptance to result when unstalled. With STAGES=1, the result is registered one cycle after acceptance.
- **Throughput:** one result per cycle while `out_ready`=1.
- **Reset:**
  - On `rst_n`=0, immediately and asynchronously, all valid bits clear.
  - `out_valid`=0, `Sum`=0, `Cout`=0, `V`=0, `Z`=0.
  - `in_ready` = 1 once reset is applied, since `out_valid`=0.
  - Reset mid-operation discards all in-flight transactions. No output is produced for them after release.
- **Simultaneous events:** an output handshake and an input handshake in the same cycle are both honoured. The pipeline shifts by one.
- **Wrap-around:** `Sum` wraps modulo 2^WIDTH. Cout and V report the overflow.
- **Idle inputs:** `A`/`B`/`Op`/`Cin` are don't-care when `in_valid`=0. Bubble stages must not update `out_valid`.

## Structure
- **Package `adder_pkg`:**
  - `typedef enum logic {OP_ADD, OP_SUB} op_e`.
  - `typedef struct packed {logic cout, v, z;} add_flags_t`.
  - Helper function `slice_w(WIDTH, STAGES)`.
- **Sub-module `adder_slice #(SW)`:** combinational SW-bit add with carry in/out, instantiated once per stage. It may wrap `prefix_adder` internally.
- **Top `pipe_adder`:** stage registers, skew registers, valid/stall control and flag logic. An elaboration-time assertion checks `WIDTH % STAGES == 0` and `STAGES ≥ 1`.

## Test plan
All scenarios use WIDTH=32, STAGES=4 unless stated.
1. `A`=0xFFFFFFFF, `B`=0x00000001, `Cin`=0, ADD → 4 cycles later `Sum`=0x00000000, `Cout`=1, `Z`=1, `V`=0.
2. SUB `A`=5, `B`=7, `Cin`=0 → `Sum`=0xFFFFFFFE, `Cout`=0, `V`=0. SUB `A`=7, `B`=5, `Cin`=1 → `Sum`=1, `Cout`=1.
3. ADD `A`=0x7FFFFFFF, `B`=1 → `Sum`=0x80000000, `V`=1, `Cout`=0. SUB `A`=0x80000000, `B`=1, `Cin`=0 → `Sum`=0x7FFFFFFF, `V`=1.
4. Stream 64 random transactions back-to-back with `out_ready`=1 → one result per cycle, each matching `A±B±Cin` against a reference model, in order.
5. Stream input while `out_ready` is held low for 10 cycles mid-stream:
   - `in_ready` drops within one cycle of the stall reaching the output.
   - Outputs hold steady during the stall.
   - After release, all results arrive in order, with none lost or duplicated.
6. Assert `rst_n`=0 with 3 transactions in flight → outputs clear asynchronously. After release no stale `out_valid`; a new ADD 2+3 returns `Sum`=5 after 4 cycles. Repeat scenario 1 with WIDTH=8, STAGES=1 and WIDTH=64, STAGES=8.
